// File: rtl/muldiv_unit_pkg.sv
// Shared widths, op codes and FSM states for the MIPS32 multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned CNT_WIDTH  = 5;
  localparam int unsigned MD_OP_W    = 3;

  localparam logic [MD_OP_W-1:0] MD_OP_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_OP_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_OP_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_OP_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_step.sv
// Single radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module md_step #(
  parameter int unsigned W = 32
) (
  input  logic         mode,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] shreg,
  input  logic [W-1:0] b,
  output logic [W-1:0] acc_nxt,
  output logic [W-1:0] shreg_nxt
);

  logic [W:0] sum;
  logic [W:0] rem_sh;
  logic [W:0] diff;

  always_comb begin
    sum       = {1'b0, acc} + (shreg[0] ? {1'b0, b} : '0);
    rem_sh    = {acc, shreg[W-1]};
    diff      = rem_sh - {1'b0, b};
    acc_nxt   = '0;
    shreg_nxt = '0;
    if (mode) begin
      // diff[W] is the borrow: no borrow means the divisor fit, quotient bit 1
      acc_nxt   = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
      shreg_nxt = {shreg[W-2:0], ~diff[W]};
    end else begin
      acc_nxt   = sum[W:1];
      shreg_nxt = {sum[0], shreg[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit with architectural HI/LO registers.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned W     = WORD_WIDTH,
  parameter int unsigned CNT_W = CNT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic               flush,
  input  logic [W-1:0]       rs_data,
  input  logic [W-1:0]       rt_data,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       hi,
  output logic [W-1:0]       lo
);

  md_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]   acc, shreg, b;
  logic [W-1:0]   acc_nxt, shreg_nxt;
  logic           is_div, neg_q, neg_r;

  logic           op_signed, op_div, op_arith, div_zero, sa, sb;
  logic [W-1:0]   a_abs, b_abs;
  logic [2*W-1:0] prod;

  md_step #(.W(W)) u_step (
    .mode      (is_div),
    .acc       (acc),
    .shreg     (shreg),
    .b         (b),
    .acc_nxt   (acc_nxt),
    .shreg_nxt (shreg_nxt)
  );

  always_comb begin
    op_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    op_div    = (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    op_arith  = op_div || (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    div_zero  = op_div && (rt_data == '0);
    sa        = op_signed && rs_data[W-1];
    sb        = op_signed && rt_data[W-1];
    a_abs     = sa ? -rs_data : rs_data;
    b_abs     = sb ? -rt_data : rt_data;
    prod      = neg_q ? -{acc, shreg} : {acc, shreg};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start && !flush && op_arith) state_nxt = MD_RUN;
      MD_RUN: begin
        if (flush)           state_nxt = MD_IDLE;
        else if (cnt == '0)  state_nxt = MD_FIX;
      end
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign busy = (state != MD_IDLE);
  assign done = (state == MD_FIX) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      shreg  <= '0;
      b      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start && !flush) begin
            if (op == MD_OP_MTHI) hi <= rs_data;
            if (op == MD_OP_MTLO) lo <= rs_data;
            if (op_arith) begin
              // Divide-by-zero runs the raw dividend through the same loop:
              // with b=0 every step succeeds, leaving lo=all-ones and hi=dividend.
              acc    <= '0;
              shreg  <= div_zero ? rs_data : a_abs;
              b      <= b_abs;
              is_div <= op_div;
              neg_q  <= !div_zero && (sa ^ sb);
              neg_r  <= !div_zero && op_div && sa;
              cnt    <= CNT_W'(W - 1);
            end
          end
        end
        MD_RUN: begin
          acc   <= acc_nxt;
          shreg <= shreg_nxt;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        MD_FIX: begin
          if (!flush) begin
            if (is_div) begin
              lo <= neg_q ? -shreg : shreg;
              hi <= neg_r ? -acc : acc;
            end else begin
              hi <= prod[2*W-1:W];
              lo <= prod[W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic        flush = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.W(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Issues one op at the current negedge and follows it until busy drops.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] bb,
                        output int busy_cycles, output int done_cnt);
    start = 1'b1; op = o; rs_data = a; rt_data = bb;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    done_cnt = 0;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      if (done) done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi got %h want 0", hi); end
    tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo got %h want 0", lo); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int bc, dc;
    run_op(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7, bc, dc);
    tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
    tests_run++; if (dc !== 1) begin tests_failed++; $display("FAIL mult_done_pulses got %0d want 1", dc); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    tests_run++; if (lo !== 32'hFFFF_FFEB) begin tests_failed++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    run_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
    tests_run++; if (hi !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    tests_run++; if (lo !== 32'h0000_0001) begin tests_failed++; $display("FAIL multu_lo got %h want 00000001", lo); end
  endtask

  task automatic test_div();
    int bc, dc;
    run_op(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, bc, dc);
    tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL div_busy_cycles got %0d want 33", bc); end
    tests_run++; if (dc !== 1) begin tests_failed++; $display("FAIL div_done_pulses got %0d want 1", dc); end
    tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_lo got %h want fffffffd", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_hi got %h want ffffffff", hi); end
    run_op(MD_OP_DIV, 32'd7, 32'hFFFF_FFFE, bc, dc);
    tests_run++; if (lo !== 32'hFFFF_FFFD) begin tests_failed++; $display("FAIL div_negdivisor_lo got %h want fffffffd", lo); end
    tests_run++; if (hi !== 32'h0000_0001) begin tests_failed++; $display("FAIL div_negdivisor_hi got %h want 00000001", hi); end
  endtask

  task automatic test_div_boundaries();
    int bc, dc;
    run_op(MD_OP_DIVU, 32'd7, 32'd0, bc, dc);
    tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL divu0_busy_cycles got %0d want 33", bc); end
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL divu0_lo got %h want ffffffff", lo); end
    tests_run++; if (hi !== 32'd7) begin tests_failed++; $display("FAIL divu0_hi got %h want 00000007", hi); end
    run_op(MD_OP_DIV, 32'hFFFF_FFFB, 32'd0, bc, dc);
    tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div0_lo got %h want ffffffff", lo); end
    tests_run++; if (hi !== 32'hFFFF_FFFB) begin tests_failed++; $display("FAIL div0_hi got %h want fffffffb", hi); end
    run_op(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc);
    tests_run++; if (lo !== 32'h8000_0000) begin tests_failed++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
  endtask

  task automatic test_mthi_mtlo();
    int waited;
    start = 1'b1; op = MD_OP_MTHI; rs_data = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (hi !== 32'h1234_5678) begin tests_failed++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mthi_busy got %b want 0", busy); end
    start = 1'b1; op = MD_OP_MTLO; rs_data = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (lo !== 32'hCAFE_0001) begin tests_failed++; $display("FAIL mtlo_lo got %h want cafe0001", lo); end
    tests_run++; if (hi !== 32'h1234_5678) begin tests_failed++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi); end
    // MTHI while a MULTU is in flight must be dropped
    start = 1'b1; op = MD_OP_MULTU; rs_data = 32'd3; rt_data = 32'd5;
    @(negedge clk);
    op = MD_OP_MTHI; rs_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    tests_run++; if (hi !== 32'h1234_5678) begin tests_failed++; $display("FAIL mthi_busy_hi got %h want 12345678", hi); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mthi_busy_busy got %b want 1", busy); end
    waited = 0;
    while (busy && waited < 100) begin waited++; @(negedge clk); end
    tests_run++; if (waited !== 32) begin tests_failed++; $display("FAIL mthi_busy_remaining got %0d want 32", waited); end
    tests_run++; if (lo !== 32'd15) begin tests_failed++; $display("FAIL mthi_busy_lo got %h want 0000000f", lo); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL mthi_busy_final_hi got %h want 00000000", hi); end
  endtask

  task automatic test_flush();
    int waited, seen_done;
    start = 1'b1; op = MD_OP_MTHI; rs_data = 32'hAAAA_0000; @(negedge clk);
    op = MD_OP_MTLO; rs_data = 32'h0000_5555; @(negedge clk);
    // flush during RUN
    op = MD_OP_DIVU; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    repeat (9) begin if (done) seen_done++; @(negedge clk); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_run_busy got %b want 0", busy); end
    tests_run++; if (seen_done !== 0) begin tests_failed++; $display("FAIL flush_run_done got %0d want 0", seen_done); end
    tests_run++; if (hi !== 32'hAAAA_0000) begin tests_failed++; $display("FAIL flush_run_hi got %h want aaaa0000", hi); end
    tests_run++; if (lo !== 32'h0000_5555) begin tests_failed++; $display("FAIL flush_run_lo got %h want 00005555", lo); end
    // flush during FIX: 32 RUN cycles, FIX is the 33rd busy cycle
    start = 1'b1; op = MD_OP_DIVU;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL flush_fix_at_fix got done=%b want 1", done); end
    flush = 1'b1;
    #1;
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL flush_fix_done got %b want 0", done); end
    @(negedge clk);
    flush = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_fix_busy got %b want 0", busy); end
    tests_run++; if (hi !== 32'hAAAA_0000) begin tests_failed++; $display("FAIL flush_fix_hi got %h want aaaa0000", hi); end
    tests_run++; if (lo !== 32'h0000_5555) begin tests_failed++; $display("FAIL flush_fix_lo got %h want 00005555", lo); end
    // flush together with start in IDLE, and an unknown op code
    start = 1'b1; flush = 1'b1; op = MD_OP_MTHI; rs_data = 32'h0BAD_0BAD;
    @(negedge clk);
    op = MD_OP_MULT;
    @(negedge clk);
    flush = 1'b0; op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_flush_busy got %b want 0", busy); end
    tests_run++; if (hi !== 32'hAAAA_0000) begin tests_failed++; $display("FAIL idle_flush_hi got %h want aaaa0000", hi); end
    tests_run++; if (lo !== 32'h0000_5555) begin tests_failed++; $display("FAIL idle_flush_lo got %h want 00005555", lo); end
  endtask

  task automatic test_reset_midop();
    int bc, dc;
    start = 1'b1; op = MD_OP_MULTU; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_hi got %h want 0", hi); end
    tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_lo got %h want 0", lo); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(MD_OP_MULTU, 32'd3, 32'd5, bc, dc);
    tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL rst_after_busy_cycles got %0d want 33", bc); end
    tests_run++; if (lo !== 32'd15) begin tests_failed++; $display("FAIL rst_after_lo got %h want 0000000f", lo); end
    tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL rst_after_hi got %h want 00000000", hi); end
  endtask

  task automatic test_back_to_back();
    int bc, dc;
    run_op(MD_OP_MULT, 32'h7FFF_FFFF, 32'd2, bc, dc);
    tests_run++; if (lo !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL b2b_mult_lo got %h want fffffffe", lo); end
    tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL b2b_mult_hi got %h want 00000000", hi); end
    run_op(MD_OP_DIVU, 32'hFFFF_FFFF, 32'h10, bc, dc);
    tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL b2b_divu_busy_cycles got %0d want 33", bc); end
    tests_run++; if (lo !== 32'h0FFF_FFFF) begin tests_failed++; $display("FAIL b2b_divu_lo got %h want 0fffffff", lo); end
    tests_run++; if (hi !== 32'h0000_000F) begin tests_failed++; $display("FAIL b2b_divu_hi got %h want 0000000f", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_boundaries();
    test_mthi_mtlo();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
